// File: rtl/raifes_dmi_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// raifes_dmi_arbiter_pkg
//   Shared definitions for the DMI sequencer/arbiter:
//   - DMI_ADDR_WIDTH / DMI_WIDTH : DMI bus geometry
//   - arb_state_e                : 2-bit arbiter FSM state encoding
//   - owner_onehot()             : maps a requester index to a one-hot vector
// -----------------------------------------------------------------------------
package raifes_dmi_arbiter_pkg;

  localparam int DMI_ADDR_WIDTH = 7;
  localparam int DMI_WIDTH      = 32;
  localparam int NUM_REQ        = 2;

  // Arbiter FSM state encodings.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // arbitrate between requesters
    ST_ISSUE = 2'd1,  // hold the access until the DM is idle, then strobe
    ST_WAIT  = 2'd2,  // wait for DM completion or timeout
    ST_RESP  = 2'd3   // present the response to the owner
  } arb_state_e;

  // One-hot vector for a requester index (index 0 -> 2'b01, 1 -> 2'b10).
  function automatic logic [NUM_REQ-1:0] owner_onehot(input logic owner);
    return owner ? 2'b10 : 2'b01;
  endfunction

endpackage : raifes_dmi_arbiter_pkg

// File: rtl/raifes_dmi_arbiter_if.sv
// -----------------------------------------------------------------------------
// raifes_dmi_arbiter_if
//   Request/response channel between one DMI requester and the arbiter.
//   Request  : req_valid, req_ready, req_addr, req_wdata, req_wen (1 = write)
//   Response : rsp_valid, rsp_ready, rsp_rdata, rsp_error
//   Modports : master (requester side), slave (arbiter side)
// -----------------------------------------------------------------------------
interface raifes_dmi_arbiter_if;
  import raifes_dmi_arbiter_pkg::*;

  logic                      req_valid;
  logic                      req_ready;
  logic [DMI_ADDR_WIDTH-1:0] req_addr;
  logic [DMI_WIDTH-1:0]      req_wdata;
  logic                      req_wen;

  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [DMI_WIDTH-1:0]      rsp_rdata;
  logic                      rsp_error;

  modport master (
    output req_valid, req_addr, req_wdata, req_wen, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_addr, req_wdata, req_wen, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );

endinterface : raifes_dmi_arbiter_if

// File: rtl/raifes_dmi_rr_arb.sv
// -----------------------------------------------------------------------------
// raifes_dmi_rr_arb
//   Two-way round-robin grant logic, purely combinational.
//   i_valid      : request vector, bit N = requester N
//   i_last_grant : index of the requester granted most recently
//   o_grant      : one-hot grant (all zero when nobody requests)
//   On a tie the requester that was NOT granted last time wins.
// -----------------------------------------------------------------------------
module raifes_dmi_rr_arb (
  input  logic [1:0] i_valid,
  input  logic       i_last_grant,
  output logic [1:0] o_grant
);

  always_comb begin
    // NOTE: give every always_comb output a default first so no path can leave it
    // unassigned, which would otherwise infer a latch.
    o_grant = 2'b00;
    case (i_valid)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = i_last_grant ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

endmodule : raifes_dmi_rr_arb

// File: rtl/raifes_dmi_arbiter.sv
// -----------------------------------------------------------------------------
// raifes_dmi_arbiter
//   Sequencer and two-way arbiter in front of the single Debug Module port.
//   Requester 0 is the synchronized JTAG DTM path, requester 1 a second debug
//   host. Requests are serialized, held off while the DM is busy, bounded by a
//   timeout, and answered to the requester that owns the access.
//
//   Parameters:
//     TIMEOUT     : max busy cycles after issue before answering with an error;
//                   0 disables the timeout.
//   Ports:
//     clk, rst_n  : system clock, asynchronous active-low reset
//     m0, m1      : requester channels (raifes_dmi_arbiter_if.slave)
//     dmi_addr    : address to the DM (holds the last issued value)
//     dmi_wdata   : write data to the DM (holds the last issued value)
//     dmi_en      : single-cycle access strobe
//     dmi_wen     : write qualifier, only high together with dmi_en
//     dmi_rdata   : DM read data
//     dmi_error   : DM error flag
//     dmi_dm_busy : DM is processing an access
// -----------------------------------------------------------------------------
module raifes_dmi_arbiter
  import raifes_dmi_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,

  raifes_dmi_arbiter_if.slave       m0,
  raifes_dmi_arbiter_if.slave       m1,

  output logic [DMI_ADDR_WIDTH-1:0] dmi_addr,
  output logic [DMI_WIDTH-1:0]      dmi_wdata,
  output logic                      dmi_en,
  output logic                      dmi_wen,
  input  logic [DMI_WIDTH-1:0]      dmi_rdata,
  input  logic                      dmi_error,
  input  logic                      dmi_dm_busy
);

  // A zero-width counter is not legal, so a disabled timeout keeps one bit.
  localparam int                   CNT_W       = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]     TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]     CNT_MAX     = '1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  arb_state_e                r_state;
  logic                      r_last_grant;
  logic                      r_owner;

  // Request latched at the handshake, replayed when the DM becomes idle.
  logic [DMI_ADDR_WIDTH-1:0] r_addr;
  logic [DMI_WIDTH-1:0]      r_wdata;
  logic                      r_wen;

  // Registered DM-side outputs.
  logic                      r_dmi_en;
  logic                      r_dmi_wen;
  logic [DMI_ADDR_WIDTH-1:0] r_dmi_addr;
  logic [DMI_WIDTH-1:0]      r_dmi_wdata;

  // Registered response.
  logic [NUM_REQ-1:0]        r_rsp_valid;
  logic [DMI_WIDTH-1:0]      r_rsp_rdata;
  logic                      r_rsp_error;

  logic [CNT_W-1:0]          r_cnt;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic [NUM_REQ-1:0]        w_valid;
  logic [NUM_REQ-1:0]        w_grant;
  logic                      w_idle;
  logic                      w_hs;
  logic [DMI_ADDR_WIDTH-1:0] w_sel_addr;
  logic [DMI_WIDTH-1:0]      w_sel_wdata;
  logic                      w_sel_wen;
  logic                      w_rsp_ready;
  logic [CNT_W-1:0]          w_cnt_inc;
  logic                      w_timeout;

  assign w_valid = {m1.req_valid, m0.req_valid};

  raifes_dmi_rr_arb u_rr_arb (
    .i_valid      (w_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant)
  );

  assign w_idle       = (r_state == ST_IDLE);
  assign m0.req_ready = w_idle & w_grant[0];
  assign m1.req_ready = w_idle & w_grant[1];
  assign w_hs         = w_idle & (|w_grant);

  assign w_sel_addr   = w_grant[1] ? m1.req_addr  : m0.req_addr;
  assign w_sel_wdata  = w_grant[1] ? m1.req_wdata : m0.req_wdata;
  assign w_sel_wen    = w_grant[1] ? m1.req_wen   : m0.req_wen;

  assign w_rsp_ready  = r_owner ? m1.rsp_ready : m0.rsp_ready;

  // Saturating increment; the timeout fires on the busy cycle that brings the
  // count up to TIMEOUT, so exactly TIMEOUT busy cycles are tolerated.
  assign w_cnt_inc    = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_timeout    = (TIMEOUT != 0) && (w_cnt_inc == TIMEOUT_CNT);

  // ---------------------------------------------------------------------------
  // FSM with registered outputs
  //
  // The strobe is registered: the decision to issue is taken one edge earlier
  // from the busy flag seen then. On an uncontested handshake with the DM idle
  // the strobe is therefore set on the handshake edge itself, and ISSUE only
  // lasts the strobe cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // The data registers are reset too: the DM-facing bus and the response
      // data must read as zero straight out of reset.
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wen        <= 1'b0;
      r_dmi_en     <= 1'b0;
      r_dmi_wen    <= 1'b0;
      r_dmi_addr   <= '0;
      r_dmi_wdata  <= '0;
      r_rsp_valid  <= '0;
      r_rsp_rdata  <= '0;
      r_rsp_error  <= 1'b0;
      r_cnt        <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values; the defaults below are then safely overridden.
      r_dmi_en  <= 1'b0;
      r_dmi_wen <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_hs) begin
            r_addr       <= w_sel_addr;
            r_wdata      <= w_sel_wdata;
            r_wen        <= w_sel_wen;
            r_owner      <= w_grant[1];
            r_last_grant <= w_grant[1];
            r_state      <= ST_ISSUE;
            if (!dmi_dm_busy) begin
              r_dmi_en    <= 1'b1;
              r_dmi_wen   <= w_sel_wen;
              r_dmi_addr  <= w_sel_addr;
              r_dmi_wdata <= w_sel_wdata;
            end
          end
        end

        ST_ISSUE: begin
          if (r_dmi_en) begin
            // Strobe is on the bus this cycle; start watching completion.
            r_state <= ST_WAIT;
            r_cnt   <= '0;
          end else if (!dmi_dm_busy) begin
            r_dmi_en    <= 1'b1;
            r_dmi_wen   <= r_wen;
            r_dmi_addr  <= r_addr;
            r_dmi_wdata <= r_wdata;
          end
        end

        ST_WAIT: begin
          if (!dmi_dm_busy) begin
            r_rsp_rdata <= dmi_rdata;
            r_rsp_error <= dmi_error;
            r_rsp_valid <= owner_onehot(r_owner);
            r_state     <= ST_RESP;
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_timeout) begin
              r_rsp_rdata <= '0;
              r_rsp_error <= 1'b1;
              r_rsp_valid <= owner_onehot(r_owner);
              r_state     <= ST_RESP;
            end
          end
        end

        ST_RESP: begin
          if (w_rsp_ready) begin
            r_rsp_valid <= '0;
            r_state     <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign dmi_en       = r_dmi_en;
  assign dmi_wen      = r_dmi_wen;
  assign dmi_addr     = r_dmi_addr;
  assign dmi_wdata    = r_dmi_wdata;

  // Data is shared; only the owner's valid is ever raised.
  assign m0.rsp_valid = r_rsp_valid[0];
  assign m1.rsp_valid = r_rsp_valid[1];
  assign m0.rsp_rdata = r_rsp_rdata;
  assign m1.rsp_rdata = r_rsp_rdata;
  assign m0.rsp_error = r_rsp_error;
  assign m1.rsp_error = r_rsp_error;

endmodule : raifes_dmi_arbiter

// File: tb/tb_raifes_dmi_arbiter.sv
// -----------------------------------------------------------------------------
// tb_raifes_dmi_arbiter
//   Directed bench for raifes_dmi_arbiter (TIMEOUT = 8). The bench plays both
//   requesters and the DM; expected values are hand-derived cycle by cycle.
//   Inputs change 1 time unit after a rising edge, outputs are read there too.
// -----------------------------------------------------------------------------
module tb_raifes_dmi_arbiter;
  import raifes_dmi_arbiter_pkg::*;

  logic                      clk   = 1'b0;
  logic                      rst_n = 1'b0;
  logic [DMI_ADDR_WIDTH-1:0] dmi_addr;
  logic [DMI_WIDTH-1:0]      dmi_wdata;
  logic                      dmi_en;
  logic                      dmi_wen;
  logic [DMI_WIDTH-1:0]      dmi_rdata;
  logic                      dmi_error;
  logic                      dmi_dm_busy;

  raifes_dmi_arbiter_if m0_if ();
  raifes_dmi_arbiter_if m1_if ();

  raifes_dmi_arbiter #(.TIMEOUT(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .m0          (m0_if),
    .m1          (m1_if),
    .dmi_addr    (dmi_addr),
    .dmi_wdata   (dmi_wdata),
    .dmi_en      (dmi_en),
    .dmi_wen     (dmi_wen),
    .dmi_rdata   (dmi_rdata),
    .dmi_error   (dmi_error),
    .dmi_dm_busy (dmi_dm_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Strobe log and stray-response flag, sampled on the falling edge.
  logic [DMI_ADDR_WIDTH-1:0] en_addr_q[$];
  logic [DMI_WIDTH-1:0]      en_wdata_q[$];
  logic                      en_wen_q[$];
  logic                      m1_rsp_seen = 1'b0;

  always @(negedge clk) begin
    if (dmi_en === 1'b1) begin
      en_addr_q.push_back(dmi_addr);
      en_wdata_q.push_back(dmi_wdata);
      en_wen_q.push_back(dmi_wen);
    end
    if (m1_if.rsp_valid === 1'b1) m1_rsp_seen = 1'b1;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    en_addr_q.delete();
    en_wdata_q.delete();
    en_wen_q.delete();
  endtask

  task automatic test_reset();
    m0_if.req_valid = 0; m0_if.req_addr = '0; m0_if.req_wdata = '0; m0_if.req_wen = 0; m0_if.rsp_ready = 0;
    m1_if.req_valid = 0; m1_if.req_addr = '0; m1_if.req_wdata = '0; m1_if.req_wen = 0; m1_if.rsp_ready = 0;
    dmi_rdata = '0; dmi_error = 0; dmi_dm_busy = 0;
    rst_n = 0;
    step(2);
    n_checks++; if (dmi_en !== 1'b0) begin n_fail++; $display("FAIL reset_dmi_en: got %b expected 0", dmi_en); end
    n_checks++; if (dmi_wen !== 1'b0) begin n_fail++; $display("FAIL reset_dmi_wen: got %b expected 0", dmi_wen); end
    n_checks++; if (dmi_addr !== 7'h00) begin n_fail++; $display("FAIL reset_dmi_addr: got %h expected 00", dmi_addr); end
    n_checks++; if (dmi_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_dmi_wdata: got %h expected 0", dmi_wdata); end
    n_checks++; if (m0_if.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m0_rsp_valid: got %b expected 0", m0_if.rsp_valid); end
    n_checks++; if (m1_if.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m1_rsp_valid: got %b expected 0", m1_if.rsp_valid); end
    n_checks++; if (m0_if.rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_rdata: got %h expected 0", m0_if.rsp_rdata); end
    n_checks++; if (m0_if.rsp_error !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_error: got %b expected 0", m0_if.rsp_error); end
    rst_n = 1;
    step(1);
    // last_grant resets to 1, so requester 0 wins the first tie.
    m0_if.req_valid = 1; m1_if.req_valid = 1;
    #1;
    n_checks++; if (m0_if.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_tie_m0_ready: got %b expected 1", m0_if.req_ready); end
    n_checks++; if (m1_if.req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_tie_m1_ready: got %b expected 0", m1_if.req_ready); end
    m0_if.req_valid = 0; m1_if.req_valid = 0;
    #1;
  endtask

  task automatic test_single_read();
    clear_log(); m1_rsp_seen = 1'b0;
    m0_if.req_addr = 7'h11; m0_if.req_wdata = '0; m0_if.req_wen = 0; m0_if.req_valid = 1; m0_if.rsp_ready = 0;
    dmi_dm_busy = 0; dmi_rdata = '0; dmi_error = 0;
    step(1);                                   // handshake edge
    m0_if.req_valid = 0;
    n_checks++; if (dmi_en !== 1'b1) begin n_fail++; $display("FAIL read_dmi_en: got %b expected 1", dmi_en); end
    n_checks++; if (dmi_wen !== 1'b0) begin n_fail++; $display("FAIL read_dmi_wen: got %b expected 0", dmi_wen); end
    n_checks++; if (dmi_addr !== 7'h11) begin n_fail++; $display("FAIL read_dmi_addr: got %h expected 11", dmi_addr); end
    dmi_dm_busy = 1;
    step(1);                                   // into WAIT
    n_checks++; if (dmi_en !== 1'b0) begin n_fail++; $display("FAIL read_en_single: got %b expected 0", dmi_en); end
    n_checks++; if (dmi_addr !== 7'h11) begin n_fail++; $display("FAIL read_addr_hold: got %h expected 11", dmi_addr); end
    step(3);                                   // three busy samples
    n_checks++; if (m0_if.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL read_rsp_early: got %b expected 0", m0_if.rsp_valid); end
    dmi_dm_busy = 0; dmi_rdata = 32'h0003_0382;
    step(1);                                   // capture
    dmi_rdata = 32'hFFFF_FFFF;
    n_checks++; if (m0_if.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL read_rsp_valid: got %b expected 1", m0_if.rsp_valid); end
    n_checks++; if (m0_if.rsp_rdata !== 32'h0003_0382) begin n_fail++; $display("FAIL read_rsp_rdata: got %h expected 00030382", m0_if.rsp_rdata); end
    n_checks++; if (m0_if.rsp_error !== 1'b0) begin n_fail++; $display("FAIL read_rsp_error: got %b expected 0", m0_if.rsp_error); end
    m0_if.rsp_ready = 1;
    step(1);
    m0_if.rsp_ready = 0;
    n_checks++; if (m0_if.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL read_rsp_drop: got %b expected 0", m0_if.rsp_valid); end
    n_checks++; if (en_wen_q.size() !== 1) begin n_fail++; $display("FAIL read_en_count: got %0d expected 1", en_wen_q.size()); end
    else if (en_wen_q[0] !== 1'b0) begin n_fail++; $display("FAIL read_en_wen: got %b expected 0", en_wen_q[0]); end
    n_checks++; if (m1_rsp_seen !== 1'b0) begin n_fail++; $display("FAIL read_m1_rsp_seen: got %b expected 0", m1_rsp_seen); end
  endtask

  task automatic test_contested_writes();
    rst_n = 0; step(1); rst_n = 1; step(1);
    clear_log();
    m0_if.req_addr = 7'h10; m0_if.req_wdata = 32'h0000_0001; m0_if.req_wen = 1; m0_if.rsp_ready = 1;
    m1_if.req_addr = 7'h10; m1_if.req_wdata = 32'h8000_0000; m1_if.req_wen = 1; m1_if.rsp_ready = 1;
    m0_if.req_valid = 1; m1_if.req_valid = 1;
    dmi_dm_busy = 0; dmi_rdata = 32'h1234_5678; dmi_error = 0;
    step(1);                                   // m0 accepted
    m0_if.req_valid = 0;
    step(2);                                   // ISSUE -> WAIT -> RESP
    n_checks++; if (m0_if.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL wr_m0_rsp_valid: got %b expected 1", m0_if.rsp_valid); end
    n_checks++; if (m0_if.rsp_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL wr_m0_rsp_rdata: got %h expected 12345678", m0_if.rsp_rdata); end
    n_checks++; if (m1_if.req_ready !== 1'b0) begin n_fail++; $display("FAIL wr_m1_ready_busy: got %b expected 0", m1_if.req_ready); end
    step(1);                                   // response consumed, IDLE
    n_checks++; if (m1_if.req_ready !== 1'b1) begin n_fail++; $display("FAIL wr_m1_ready: got %b expected 1", m1_if.req_ready); end
    step(1);                                   // m1 accepted
    m1_if.req_valid = 0;
    step(2);
    n_checks++; if (m1_if.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL wr_m1_rsp_valid: got %b expected 1", m1_if.rsp_valid); end
    n_checks++; if (m0_if.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_m0_rsp_other: got %b expected 0", m0_if.rsp_valid); end
    step(1);
    n_checks++; if (en_wen_q.size() !== 2) begin n_fail++; $display("FAIL wr_en_count: got %0d expected 2", en_wen_q.size()); end
    else begin
      n_checks++; if (en_wdata_q[0] !== 32'h0000_0001 || en_wen_q[0] !== 1'b1) begin n_fail++; $display("FAIL wr_first: got %h/%b expected 00000001/1", en_wdata_q[0], en_wen_q[0]); end
      n_checks++; if (en_wdata_q[1] !== 32'h8000_0000 || en_wen_q[1] !== 1'b1) begin n_fail++; $display("FAIL wr_second: got %h/%b expected 80000000/1", en_wdata_q[1], en_wen_q[1]); end
    end
    m0_if.rsp_ready = 0; m1_if.rsp_ready = 0;
  endtask

  task automatic test_busy_holdoff();
    // Uncontested m0 access makes requester 0 the last grant.
    m0_if.req_addr = 7'h04; m0_if.req_wen = 0; m0_if.req_valid = 1; m0_if.rsp_ready = 1;
    dmi_dm_busy = 0;
    step(1);
    m0_if.req_valid = 0;
    step(3);
    clear_log();
    // Contested with last_grant = 0: requester 1 wins; DM already busy.
    dmi_dm_busy = 1;
    m0_if.req_addr = 7'h05; m0_if.req_valid = 1;
    m1_if.req_addr = 7'h06; m1_if.req_wen = 0; m1_if.req_valid = 1; m1_if.rsp_ready = 1;
    #1;
    n_checks++; if (m1_if.req_ready !== 1'b1) begin n_fail++; $display("FAIL rr_m1_ready: got %b expected 1", m1_if.req_ready); end
    n_checks++; if (m0_if.req_ready !== 1'b0) begin n_fail++; $display("FAIL rr_m0_ready: got %b expected 0", m0_if.req_ready); end
    step(1);                                   // m1 accepted while busy
    m1_if.req_valid = 0;
    n_checks++; if (dmi_en !== 1'b0) begin n_fail++; $display("FAIL hold_en_0: got %b expected 0", dmi_en); end
    step(2);
    n_checks++; if (en_addr_q.size() !== 0) begin n_fail++; $display("FAIL hold_en_count: got %0d expected 0", en_addr_q.size()); end
    dmi_dm_busy = 0; dmi_rdata = 32'hA5A5_0006;
    step(1);
    n_checks++; if (dmi_en !== 1'b1 || dmi_addr !== 7'h06) begin n_fail++; $display("FAIL hold_issue: got en %b addr %h expected 1/06", dmi_en, dmi_addr); end
    step(2);
    n_checks++; if (m1_if.rsp_valid !== 1'b1 || m1_if.rsp_rdata !== 32'hA5A5_0006) begin n_fail++; $display("FAIL hold_rsp: got %b/%h expected 1/a5a50006", m1_if.rsp_valid, m1_if.rsp_rdata); end
    step(1);                                   // response consumed, m0 still waiting
    n_checks++; if (m0_if.req_ready !== 1'b1) begin n_fail++; $display("FAIL rr_m0_next: got %b expected 1", m0_if.req_ready); end
    n_checks++; if (en_addr_q.size() !== 1) begin n_fail++; $display("FAIL hold_single_en: got %0d expected 1", en_addr_q.size()); end
    step(1);
    m0_if.req_valid = 0;
    n_checks++; if (dmi_en !== 1'b1 || dmi_addr !== 7'h05) begin n_fail++; $display("FAIL rr_m0_issue: got en %b addr %h expected 1/05", dmi_en, dmi_addr); end
    step(3);
    m0_if.rsp_ready = 0; m1_if.rsp_ready = 0;
  endtask

  task automatic test_timeout();
    clear_log();
    m0_if.req_addr = 7'h20; m0_if.req_wen = 0; m0_if.req_valid = 1; m0_if.rsp_ready = 0;
    dmi_dm_busy = 0; dmi_rdata = 32'hFFFF_FFFF; dmi_error = 0;
    step(1);
    m0_if.req_valid = 0;
    dmi_dm_busy = 1;
    step(1);                                   // into WAIT
    step(7);                                   // seven busy samples
    n_checks++; if (m0_if.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL to_early: got %b expected 0", m0_if.rsp_valid); end
    step(1);                                   // eighth busy sample
    n_checks++; if (m0_if.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL to_rsp_valid: got %b expected 1", m0_if.rsp_valid); end
    n_checks++; if (m0_if.rsp_error !== 1'b1) begin n_fail++; $display("FAIL to_rsp_error: got %b expected 1", m0_if.rsp_error); end
    n_checks++; if (m0_if.rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL to_rsp_rdata: got %h expected 0", m0_if.rsp_rdata); end
    m0_if.rsp_ready = 1; dmi_dm_busy = 0;
    step(1);
    m0_if.rsp_ready = 0;
    n_checks++; if (m0_if.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL to_rsp_drop: got %b expected 0", m0_if.rsp_valid); end
    m0_if.req_valid = 1;
    #1;
    n_checks++; if (m0_if.req_ready !== 1'b1) begin n_fail++; $display("FAIL to_back_idle: got %b expected 1", m0_if.req_ready); end
    m0_if.req_valid = 0;
    #1;
    n_checks++; if (en_addr_q.size() !== 1) begin n_fail++; $display("FAIL to_en_count: got %0d expected 1", en_addr_q.size()); end
  endtask

  task automatic test_backpressure_reset();
    m1_if.req_addr = 7'h30; m1_if.req_wen = 0; m1_if.req_valid = 1; m1_if.rsp_ready = 0;
    dmi_dm_busy = 0; dmi_rdata = 32'h0BAD_F00D; dmi_error = 0;
    step(1);
    m1_if.req_valid = 0;
    step(2);
    n_checks++; if (m1_if.rsp_valid !== 1'b1 || m1_if.rsp_rdata !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL bp_rsp: got %b/%h expected 1/0badf00d", m1_if.rsp_valid, m1_if.rsp_rdata); end
    dmi_rdata = 32'h0;
    m0_if.req_addr = 7'h31; m0_if.req_wdata = 32'h0000_0055; m0_if.req_wen = 1; m0_if.req_valid = 1; m0_if.rsp_ready = 0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      n_checks++; if (m1_if.rsp_valid !== 1'b1 || m1_if.rsp_rdata !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL bp_hold_%0d: got %b/%h expected 1/0badf00d", i, m1_if.rsp_valid, m1_if.rsp_rdata); end
      n_checks++; if (m0_if.req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_no_ready_%0d: got %b expected 0", i, m0_if.req_ready); end
    end
    m1_if.rsp_ready = 1;
    step(1);
    m1_if.rsp_ready = 0;
    n_checks++; if (m0_if.req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_next_ready: got %b expected 1", m0_if.req_ready); end
    step(1);                                   // m0 write accepted
    m0_if.req_valid = 0;
    n_checks++; if (dmi_en !== 1'b1 || dmi_addr !== 7'h31 || dmi_wdata !== 32'h55) begin n_fail++; $display("FAIL bp_issue: got %b/%h/%h expected 1/31/00000055", dmi_en, dmi_addr, dmi_wdata); end
    dmi_dm_busy = 1;
    step(1);                                   // in WAIT
    rst_n = 0;
    #1;
    n_checks++; if (dmi_addr !== 7'h00 || dmi_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_dmi_bus: got %h/%h expected 00/00000000", dmi_addr, dmi_wdata); end
    n_checks++; if (dmi_en !== 1'b0 || dmi_wen !== 1'b0) begin n_fail++; $display("FAIL rst_dmi_strobe: got %b/%b expected 0/0", dmi_en, dmi_wen); end
    n_checks++; if (m1_if.rsp_rdata !== 32'h0 || m1_if.rsp_error !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_data: got %h/%b expected 0/0", m1_if.rsp_rdata, m1_if.rsp_error); end
    step(2);
    rst_n = 1; dmi_dm_busy = 0;
    step(4);
    n_checks++; if (m0_if.rsp_valid !== 1'b0 || m1_if.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_no_rsp: got %b/%b expected 0/0", m0_if.rsp_valid, m1_if.rsp_valid); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contested_writes();
    test_busy_holdoff();
    test_timeout();
    test_backpressure_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_raifes_dmi_arbiter
